apb_master_arbiter: RTL and testbench

Shares one APB master port among `NUM_REQ` internal requesters using round-robin arbitration. It sequences each granted request through the APB SETUP/ACCESS phases, honours `pready` wait states, and aborts stalled transfers with a wait-state timeout. It returns read data and error status to the requester that issued the transfer. It sits between bus-master agents (DMA, CPU bridge, test drivers) and the `apb_if` bus that feeds `apb_slave` instances.

---
 rtl/apb_master_arbiter_pkg.sv | 20 ++
 rtl/apb_master_arbiter_rr.sv | 69 ++++++
 rtl/apb_master_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter_pkg
// Shared definitions for the APB master arbiter slice:
//   - APB_ADDR_W / APB_DATA_W : default APB address and data widths
//   - apb_arb_state_e         : transfer sequencing FSM states
// -----------------------------------------------------------------------------
package apb_master_arbiter_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  // IDLE: arbitrate, SETUP/ACCESS: APB phases, RESP: one-cycle completion pulse
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_arb_state_e;

endpackage : apb_master_arbiter_pkg

// File: rtl/apb_master_arbiter_rr.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
// Round-robin winner selection for the APB master arbiter. Owns the
// last_grant pointer; the search for a winner starts at last_grant+1 modulo
// NUM_REQ, so the requester served last has the lowest priority next time.
//
// Ports:
//   clk_i       in   clock, rising edge
//   rst_i       in   asynchronous active-high reset (last_grant -> NUM_REQ-1)
//   req_i       in   request vector, one bit per requester
//   upd_i       in   strobe: load last_grant from upd_idx_i (asserted in RESP)
//   upd_idx_i   in   index of the requester that just completed
//   win_oh_o    out  one-hot winner among req_i (zero when req_i is zero)
//   win_idx_o   out  index of the winner (zero when req_i is zero)
// -----------------------------------------------------------------------------
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               upd_i,
  input  logic [IDX_W-1:0]   upd_idx_i,
  output logic [NUM_REQ-1:0] win_oh_o,
  output logic [IDX_W-1:0]   win_idx_o
);

  logic [IDX_W-1:0]   last_q;
  logic [NUM_REQ-1:0] win_oh_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [IDX_W-1:0]   cand_s;
  logic               found_s;
  logic               hit_s;
  int                 cand_int_s;

  // Pointer to the requester served most recently; reset makes requester 0 first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else if (upd_i) begin
      last_q <= upd_idx_i;
    end else begin
      last_q <= last_q;
    end
  end

  // Walk the requesters in rotated order; the first valid one wins.
  always_comb begin
    win_oh_s   = '0;
    win_idx_s  = '0;
    found_s    = 1'b0;
    hit_s      = 1'b0;
    cand_s     = '0;
    cand_int_s = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_int_s = (int'(last_q) + k) % NUM_REQ;
      cand_s     = IDX_W'(cand_int_s);
      hit_s      = !found_s && req_i[cand_s];
      win_oh_s   = win_oh_s | (hit_s ? (NUM_REQ'(1) << cand_s) : NUM_REQ'(0));
      win_idx_s  = hit_s ? cand_s : win_idx_s;
      found_s    = found_s | hit_s;
    end
  end

  assign win_oh_o  = win_oh_s;
  assign win_idx_o = win_idx_s;

endmodule : apb_rr_arbiter

// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
// Shares one APB master port among NUM_REQ requesters. A round-robin winner
// is picked in IDLE, its fields are latched, and the transfer is sequenced
// through SETUP and ACCESS. ACCESS honours pready wait states and aborts
// with an error after TIMEOUT consecutive low-pready cycles (TIMEOUT=0
// disables the abort). The result is returned as a one-cycle resp_valid
// pulse to the requester that issued the transfer. Every output is a
// register.
//
// Ports:
//   pclk, rst             clock; asynchronous active-high reset
//   req_valid/req_write   per-requester request and direction (1 = write)
//   req_addr/req_wdata    packed per-requester address / write data (slice i)
//   req_grant             one-hot owner of the bus, SETUP through RESP
//   resp_valid            one-hot single-cycle completion pulse
//   resp_rdata/resp_err   read data (0 for writes/aborts) and error status
//   psel/penable/pwrite   APB control
//   paddr/pwdata          APB address and write data
//   prdata/pready/pslverr APB slave response
// -----------------------------------------------------------------------------
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // A zero TIMEOUT still needs a one-bit counter to keep the logic well formed.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);
  // Abort fires on the ACCESS cycle whose increment would make the count TIMEOUT.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  apb_arb_state_e      state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]    idx_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [CNT_W-1:0]    wait_q;
  logic [CNT_W-1:0]    wait_d;
  logic [NUM_REQ-1:0]  resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                resp_err_q;

  logic [NUM_REQ-1:0]  win_oh_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic                sel_write_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic                timeout_hit_s;
  logic                sel_hit_s;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk_i     (pclk),
    .rst_i     (rst),
    .req_i     (req_valid),
    .upd_i     (state_q == RESP),
    .upd_idx_i (idx_q),
    .win_oh_o  (win_oh_s),
    .win_idx_o (win_idx_s)
  );

  // Select the winning requester's fields so they can be latched at grant.
  always_comb begin
    sel_write_s = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_hit_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_hit_s   = (win_idx_s == IDX_W'(i));
      sel_write_s = sel_hit_s ? req_write[i] : sel_write_s;
      sel_addr_s  = sel_hit_s ? req_addr[i*ADDR_W +: ADDR_W] : sel_addr_s;
      sel_wdata_s = sel_hit_s ? req_wdata[i*DATA_W +: DATA_W] : sel_wdata_s;
    end
  end

  // Saturating wait-state counter increment and timeout detection.
  always_comb begin
    wait_d        = (wait_q == {CNT_W{1'b1}}) ? wait_q : (wait_q + CNT_W'(1));
    timeout_hit_s = TIMEOUT_EN && (wait_q == TO_LAST);
  end

  // Transfer FSM with all APB and response outputs held in registers.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      idx_q        <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      wait_q       <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            state_q   <= SETUP;
            grant_q   <= win_oh_s;
            idx_q     <= win_idx_s;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= sel_write_s;
            paddr_q   <= sel_addr_s;
            pwdata_q  <= sel_wdata_s;
            wait_q    <= '0;
          end else begin
            state_q   <= IDLE;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            state_q      <= RESP;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_valid_q <= grant_q;
            resp_rdata_q <= pwrite_q ? '0 : prdata;
            resp_err_q   <= pslverr;
          end else if (timeout_hit_s) begin
            // Abort: the slave never answered, report an error with no data.
            state_q      <= RESP;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_valid_q <= grant_q;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
          end else begin
            wait_q       <= wait_d;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          grant_q      <= '0;
          resp_valid_q <= '0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          grant_q      <= '0;
          psel_q       <= 1'b0;
          penable_q    <= 1'b0;
          resp_valid_q <= '0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_grant  = grant_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;

endmodule : apb_master_arbiter

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
// Directed scoreboard bench: stimulus pushes hand-computed expected responses
// into a queue, a monitor pops and compares on every resp_valid pulse, and a
// small APB slave model with a memory answers the bus.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                      pclk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      resp_err;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [DATA_W-1:0]         prdata;
  logic                      pready;
  logic                      pslverr;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          lat;    // cycles from issue to resp_valid, 0 = not checked
    int          nacc;   // ACCESS cycles, 0 = not checked
    bit          chk_mem;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          issue;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks;
  int          n_errors;
  int          cyc;
  int          tmo_req;
  logic [31:0] mem [0:255];
  int          slv_waits;
  bit          stall_en;
  logic [7:0]  stall_addr;

  apb_master_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_grant  (req_grant),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge pclk);
      cyc++;
    end
  end

  // APB slave: memory writes on the completing edge, response driven at negedge.
  initial begin : slave
    int wcnt;
    wcnt    = 0;
    pready  = 1'b0;
    prdata  = 32'h0;
    pslverr = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    forever begin
      @(posedge pclk);
      if (!rst && psel && penable && pready && pwrite && paddr != 8'hFF) mem[paddr] = pwdata;
      @(negedge pclk);
      if (psel && penable) begin
        if ((stall_en && paddr == stall_addr) || wcnt < slv_waits) begin
          pready  = 1'b0;
          prdata  = 32'hDEADBEEF;
          pslverr = 1'b0;
          wcnt++;
        end else begin
          pready  = 1'b1;
          prdata  = pwrite ? 32'hBAD0BAD0 : mem[paddr];
          pslverr = (paddr == 8'hFF);
        end
      end else begin
        pready  = 1'b0;
        prdata  = 32'h0;
        pslverr = 1'b0;
        wcnt    = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor / scoreboard.
  initial begin : monitor
    int          setup_cnt;
    int          access_cnt;
    int          tmo_seen;
    logic [3:0]  prev_rv;
    logic [3:0]  exp_oh;
    exp_t        e;
    n_checks   = 0;
    n_errors   = 0;
    setup_cnt  = 0;
    access_cnt = 0;
    tmo_seen   = 0;
    prev_rv    = 4'b0;
    forever begin
      @(negedge pclk);
      if (tmo_req != tmo_seen) begin
        n_checks++;
        n_errors++;
        tmo_seen = tmo_req;
      end
      if (rst) begin
        chk("reset_outputs",
            {13'b0, psel, penable, pwrite, req_grant, resp_valid, resp_err, 8'b0} | {24'b0, paddr},
            32'h0);
        chk("reset_data", pwdata | resp_rdata, 32'h0);
        setup_cnt  = 0;
        access_cnt = 0;
        prev_rv    = 4'b0;
      end else begin
        if (psel && !penable) setup_cnt++;
        if (psel && penable) access_cnt++;
        if (resp_valid != 4'b0) begin
          chk("resp_pulse_width", {28'b0, prev_rv}, 32'h0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_resp: got resp_valid=%b, expected none", resp_valid);
          end else begin
            e      = exp_q.pop_front();
            exp_oh = 4'b0001 << e.idx;
            chk("resp_valid", {28'b0, resp_valid}, {28'b0, exp_oh});
            chk("req_grant", {28'b0, req_grant}, {28'b0, exp_oh});
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            chk("bus_idle_in_resp", {30'b0, psel, penable}, 32'h0);
            chk("setup_cycles", setup_cnt, 32'd1);
            if (e.nacc > 0) chk("access_cycles", access_cnt, e.nacc);
            if (e.lat > 0) chk("latency", cyc - e.issue + 1, e.lat);
            if (e.chk_mem) chk("slave_mem", mem[e.addr], e.wdata);
          end
          setup_cnt  = 0;
          access_cnt = 0;
        end
        prev_rv = resp_valid;
      end
    end
  end

  task automatic issue(input int i, input logic w, input logic [7:0] a, input logic [31:0] d);
    req_write[i]            = w;
    req_addr[i*8 +: 8]      = a;
    req_wdata[i*32 +: 32]   = d;
    req_valid[i]            = 1'b1;
  endtask

  task automatic push(input int idx, input logic [31:0] rd, input logic er, input int lat,
                      input int nacc, input bit cm, input logic [7:0] a, input logic [31:0] wd);
    exp_t e;
    e.idx = idx; e.rdata = rd; e.err = er; e.lat = lat; e.nacc = nacc;
    e.chk_mem = cm; e.addr = a; e.wdata = wd; e.issue = cyc;
    exp_q.push_back(e);
  endtask

  // Wait for every masked requester to see its resp_valid; clear each one
  // just after the edge at which it was sampled.
  task automatic wait_done(input logic [3:0] mask, input int budget);
    logic [3:0] done;
    logic [3:0] hit;
    int         n;
    done = 4'b0;
    n    = 0;
    while (done != mask && n < budget) begin
      @(negedge pclk);
      n++;
      hit = resp_valid & mask;
      if (hit != 4'b0) begin
        @(posedge pclk);
        #1;
        req_valid = req_valid & ~hit;
        done      = done | hit;
      end
    end
    if (done != mask) begin
      $display("FAIL wait_done: responded %b, required %b within %0d cycles", done, mask, budget);
      tmo_req++;
      req_valid = req_valid & ~mask;
    end
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge pclk);
    #1;
    rst = 1'b0;
    @(posedge pclk);
    #1;
  endtask

  initial begin : stimulus
    int n;
    rst        = 1'b1;
    req_valid  = 4'b0;
    req_write  = 4'b0;
    req_addr   = '0;
    req_wdata  = '0;
    tmo_req    = 0;
    slv_waits  = 0;
    stall_en   = 1'b0;
    stall_addr = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    rst = 1'b0;
    @(posedge pclk);
    #1;

    // Requester 0 writes then reads back, zero wait states.
    issue(0, 1'b1, 8'h32, 32'h10);
    push(0, 32'h0, 1'b0, 4, 1, 1'b1, 8'h32, 32'h10);
    wait_done(4'b0001, 50);
    issue(0, 1'b0, 8'h32, 32'h0);
    push(0, 32'h10, 1'b0, 4, 1, 1'b0, 8'h00, 32'h0);
    wait_done(4'b0001, 50);

    // All four from reset: order 0,1,2,3, one transfer per 4 cycles.
    pulse_reset(2);
    issue(0, 1'b1, 8'h32, 32'h10);
    issue(1, 1'b1, 8'h36, 32'h14);
    issue(2, 1'b1, 8'h3A, 32'h18);
    issue(3, 1'b1, 8'h3E, 32'h1C);
    push(0, 32'h0, 1'b0, 4,  1, 1'b1, 8'h32, 32'h10);
    push(1, 32'h0, 1'b0, 8,  1, 1'b1, 8'h36, 32'h14);
    push(2, 32'h0, 1'b0, 12, 1, 1'b1, 8'h3A, 32'h18);
    push(3, 32'h0, 1'b0, 16, 1, 1'b1, 8'h3E, 32'h1C);
    wait_done(4'b1111, 100);

    // Three wait states on a read of 'h36.
    slv_waits = 3;
    issue(1, 1'b0, 8'h36, 32'h0);
    push(1, 32'h14, 1'b0, 7, 4, 1'b0, 8'h00, 32'h0);
    wait_done(4'b0010, 50);
    slv_waits = 0;

    // Timeout on requester 2, requester 3 served afterwards.
    stall_en   = 1'b1;
    stall_addr = 8'h3A;
    issue(2, 1'b0, 8'h3A, 32'h0);
    issue(3, 1'b0, 8'h3E, 32'h0);
    push(2, 32'h0,  1'b1, 19, 16, 1'b0, 8'h00, 32'h0);
    push(3, 32'h1C, 1'b0, 23, 1,  1'b0, 8'h00, 32'h0);
    wait_done(4'b1100, 100);
    stall_en = 1'b0;

    // Slave error on a write to 'hFF, then normal operation.
    issue(0, 1'b1, 8'hFF, 32'h55);
    push(0, 32'h0, 1'b1, 4, 1, 1'b0, 8'h00, 32'h0);
    wait_done(4'b0001, 50);
    issue(1, 1'b0, 8'h3A, 32'h0);
    push(1, 32'h18, 1'b0, 4, 1, 1'b0, 8'h00, 32'h0);
    wait_done(4'b0010, 50);

    // Reset during ACCESS of requester 2: no response, restart from 0.
    stall_en   = 1'b1;
    stall_addr = 8'h40;
    issue(2, 1'b0, 8'h40, 32'h0);
    n = 0;
    while (!(psel && penable) && n < 20) begin
      @(negedge pclk);
      n++;
    end
    if (!(psel && penable)) begin
      $display("FAIL wait_access: penable=%b, required 1 within 20 cycles", penable);
      tmo_req++;
    end
    @(posedge pclk);
    #1;
    rst          = 1'b1;
    req_valid[2] = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    rst      = 1'b0;
    stall_en = 1'b0;
    @(posedge pclk);
    #1;
    issue(0, 1'b0, 8'h32, 32'h0);
    issue(3, 1'b0, 8'h3E, 32'h0);
    push(0, 32'h10, 1'b0, 4, 1, 1'b0, 8'h00, 32'h0);
    push(3, 32'h1C, 1'b0, 8, 1, 1'b0, 8'h00, 32'h0);
    wait_done(4'b1001, 50);

    repeat (4) @(posedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_apb_master_arbiter
